fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit datapath: holds the program counter, reads one 8-bit instruction per step from instruction memory over a ready handshake, latches it into the instruction register, and presents decoded fields to the rest of the datapath. The 2-bit immediate field goes to the sign-extension stage. The 8-bit extended value comes back and forms the branch target.

## Interface
- PC_RESET, 8'h00, PC value loaded on reset

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- imem_addr  output  8  instruction memory address (= pc)
- imem_rd  output  1  read request; high only in FETCH
- imem_ready  input  1  memory has valid data on imem_rdata this cycle
- imem_rdata  input  8  instruction word
- instr_valid  output  1  IR holds a valid instruction (DECODE state)
- opcode  output  2  ir[7:6]
- rs  output  2  ir[5:4]
- rt  output  2  ir[3:2]
- imm_field  output  2  ir[1:0], to sign-extension stage (also rd index)
- imm_ext  input  8  sign-extended imm_field, returned combinationally
- ack  input  1  downstream has consumed current instruction
- branch_taken  input  1  branch condition result, sampled with ack
- pc  output  8  current program counter

## Operation
- States: FETCH, DECODE. Reset enters FETCH.
- FETCH: imem_rd=1, imem_addr=pc. When imem_ready=1, ir<=imem_rdata and state<=DECODE. Otherwise remain in FETCH (unbounded wait).
- DECODE: instr_valid=1, imem_rd=0, ir frozen. When ack=1, update pc and set state<=FETCH. Otherwise hold.
- PC update on ack:
  - if opcode==2'b11 and branch_taken==1: pc <= pc + 8'd1 + imm_ext
  - else: pc <= pc + 8'd1
- All PC arithmetic is 8-bit modulo 256. Carry is discarded.
- Wrap: 8'hFF+1 -> 8'h00. 8'h00+1+8'hFE -> 8'hFF.
- Reachable offsets relative to pc+1: -2, -1, 0, +1.
- branch_taken is ignored when opcode!=2'b11 or ack==0.
- imem_ready is ignored outside FETCH. ack is ignored outside DECODE.
- Decoded field outputs are continuous slices of ir, valid in any state. They are meaningful only while instr_valid=1.

## Timing
- Reset values, applied asynchronously while reset_n=0:
  - pc=PC_RESET
  - ir=8'h00, so opcode/rs/rt/imm_field=0
  - state=FETCH
  - instr_valid=0
  - imem_rd=1 after release (FETCH), imem_addr=PC_RESET
- Fetch latency: imem_ready in cycle N gives instr_valid=1 from cycle N+1.
- With imem_ready held high, the minimum loop is 2 cycles per instruction: FETCH, then DECODE with ack=1.
- ack in cycle M: pc updates at edge M+1, instr_valid=0 and imem_rd=1 from cycle M+1, and imem_addr shows the new pc in cycle M+1.
- imm_ext must settle combinationally within the ack cycle. The block adds no register between imm_field and imm_ext.
- Reset mid-operation: an in-flight fetch is abandoned, a late imem_ready after release is treated as a fresh response for PC_RESET, and a held instruction is discarded.
- imem_ready and ack never coincide in effect, because they apply to different states.

## Test plan
- Reset then release, memory returns 8'h1B with ready after 3 cycles -> imem_rd=1, addr=00 for 3 cycles. Next cycle instr_valid=1 with opcode=0, rs=1, rt=2, imm_field=3. pc stays 00 until ack, then 01.
- Sequential run with zero-wait memory and ack every DECODE -> imem_addr sequence 00,01,02,03 on alternating cycles. instr_valid toggles 0/1.
- Branch: pc=10, ir=8'hC2 (opcode 11, imm 10), imm_ext=8'hFE, branch_taken=1 with ack -> pc=0F. Same with branch_taken=0 -> pc=11.
- Non-branch ignores branch_taken: opcode 01, imm_ext=01, branch_taken=1, ack -> pc=pc+1 only.
- Wrap: pc=FF, non-branch ack -> pc=00. pc=00 with branch imm_ext=8'hFE taken -> pc=FF. pc=FE with imm_ext=01 taken -> pc=00.
- reset_n pulled low mid-DECODE with ack=0, and again mid-FETCH -> immediately instr_valid=0, pc=00, ir=00. After release the first imem_addr=00. Spurious ack in FETCH and ready in DECODE cause no change.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, instruction register, FETCH/DECODE handshake
module fetch_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] imem_addr,
  output logic       imem_rd,
  input  logic       imem_ready,
  input  logic [7:0] imem_rdata,
  output logic       instr_valid,
  output logic [1:0] opcode,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] imm_field,
  input  logic [7:0] imm_ext,
  input  logic       ack,
  input  logic       branch_taken,
  output logic [7:0] pc
);

  typedef enum logic {FETCH = 1'b0, DECODE = 1'b1} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  logic       take_branch;
  logic [7:0] pc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_ready) state_next = DECODE;
      DECODE:  if (ack)        state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_rd     = (state == FETCH);
    instr_valid = (state == DECODE);
  end

  // imm_ext arrives combinationally from the sign-extension stage in the ack cycle
  assign take_branch = (opcode == 2'b11) && branch_taken;
  assign pc_next     = take_branch ? (pc + 8'd1 + imm_ext) : (pc + 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= PC_RESET;
      ir <= 8'h00;
    end else begin
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (state == DECODE && ack)       pc <= pc_next;
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir[7:6];
  assign rs        = ir[5:4];
  assign rt        = ir[3:2];
  assign imm_field = ir[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a program-counter model
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic       imem_ready = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       instr_valid;
  logic [1:0] opcode;
  logic [1:0] rs;
  logic [1:0] rt;
  logic [1:0] imm_field;
  logic [7:0] imm_ext;
  logic       ack = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] pc;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_pc = 8'h00;

  always #5 clk = ~clk;

  // Sign-extension stage stand-in
  assign imm_ext = {{6{imm_field[1]}}, imm_field};

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .imm_field   (imm_field),
    .imm_ext     (imm_ext),
    .ack         (ack),
    .branch_taken(branch_taken),
    .pc          (pc)
  );

  function automatic logic [7:0] model_next(input logic [7:0] p, input logic [7:0] ins, input logic bt);
    int off;
    off = (ins[1:0] >= 2'd2) ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
    if (ins[7:6] == 2'b11 && bt) return 8'((int'(p) + 1 + off + 256) % 256);
    return 8'((int'(p) + 1) % 256);
  endfunction

  // One instruction at the current pc; starts and ends just after a negedge in FETCH
  task automatic step(input logic [7:0] instr, input int wait_cyc, input int ack_dly, input logic bt);
    for (int k = 0; k <= wait_cyc; k++) begin
      total++;
      if (imem_rd !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc || pc !== exp_pc) begin
        bad++;
        $display("FAIL fetch_state rd=%b valid=%b addr=%h pc=%h required rd=1 valid=0 addr=%h pc=%h",
                 imem_rd, instr_valid, imem_addr, pc, exp_pc, exp_pc);
      end
      imem_ready   = (k == wait_cyc);
      imem_rdata   = (k == wait_cyc) ? instr : 8'($urandom);
      ack          = 1'($urandom);
      branch_taken = 1'($urandom);
      @(negedge clk);
    end
    for (int j = 0; j <= ack_dly; j++) begin
      total++;
      if (instr_valid !== 1'b1 || imem_rd !== 1'b0 || {opcode, rs, rt, imm_field} !== instr || pc !== exp_pc) begin
        bad++;
        $display("FAIL decode_state valid=%b rd=%b ir=%h pc=%h required valid=1 rd=0 ir=%h pc=%h",
                 instr_valid, imem_rd, {opcode, rs, rt, imm_field}, pc, instr, exp_pc);
      end
      imem_ready   = 1'($urandom);
      imem_rdata   = 8'($urandom);
      ack          = (j == ack_dly);
      branch_taken = (j == ack_dly) ? bt : 1'($urandom);
      if (j == ack_dly) exp_pc = model_next(exp_pc, instr, bt);
      @(negedge clk);
    end
    ack          = 1'b0;
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    ack = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 8'h00;
  endtask

  task automatic check_pc(input logic [7:0] want, input string name);
    total++;
    if (pc !== want) begin
      bad++;
      $display("FAIL %s pc=%h required %h", name, pc, want);
    end
  endtask

  task automatic advance_to(input logic [7:0] target);
    for (int n = 0; n < 300 && exp_pc != target; n++)
      step({2'($urandom_range(0, 2)), 6'($urandom)}, 0, 0, 1'($urandom));
    check_pc(target, "advance_target");
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (pc !== 8'h00 || instr_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h00 ||
        {opcode, rs, rt, imm_field} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state pc=%h valid=%b rd=%b addr=%h ir=%h required 00 0 1 00 00",
               pc, instr_valid, imem_rd, imem_addr, {opcode, rs, rt, imm_field});
    end
  endtask

  task automatic test_first_fetch();
    step(8'h1B, 3, 2, 1'b1);
    check_pc(8'h01, "first_fetch_pc");
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 4; i++) step({2'b01, 6'($urandom)}, 0, 0, 1'($urandom));
    check_pc(8'h04, "sequential_pc");
  endtask

  task automatic test_branch();
    advance_to(8'h10);
    step(8'hC2, 0, 0, 1'b1);
    check_pc(8'h0F, "branch_taken_pc");
    step(8'h40, 0, 0, 1'b0);
    step(8'hC2, 1, 1, 1'b0);
    check_pc(8'h11, "branch_not_taken_pc");
  endtask

  task automatic test_non_branch();
    step(8'h41, 0, 1, 1'b1);
    check_pc(8'h12, "non_branch_pc");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      step(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
  endtask

  task automatic test_wrap();
    advance_to(8'hFF);
    step(8'h40, 0, 0, 1'b1);
    check_pc(8'h00, "wrap_increment");
    step(8'hC2, 0, 0, 1'b1);
    check_pc(8'hFF, "wrap_branch_back");
    step(8'hC2, 0, 0, 1'b1);
    check_pc(8'hFE, "branch_from_ff");
    step(8'hC1, 0, 0, 1'b1);
    check_pc(8'h00, "wrap_branch_fwd");
  endtask

  task automatic check_async_reset(input string name);
    #1;
    total++;
    if (instr_valid !== 1'b0 || pc !== 8'h00 || {opcode, rs, rt, imm_field} !== 8'h00 || imem_rd !== 1'b1) begin
      bad++;
      $display("FAIL %s valid=%b pc=%h ir=%h rd=%b required 0 00 00 1",
               name, instr_valid, pc, {opcode, rs, rt, imm_field}, imem_rd);
    end
  endtask

  task automatic test_reset_mid();
    step(8'h25, 0, 0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 8'hE7;
    @(negedge clk);
    imem_ready = 1'b0;
    ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || {opcode, rs, rt, imm_field} !== 8'hE7) begin
      bad++;
      $display("FAIL pre_reset_decode valid=%b ir=%h required 1 e7", instr_valid, {opcode, rs, rt, imm_field});
    end
    #2 reset_n = 1'b0;
    check_async_reset("reset_mid_decode");
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 8'h00;
    step(8'h16, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    check_async_reset("reset_mid_fetch");
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 8'h00;
    step(8'h9A, 0, 0, 1'b1);
    check_pc(8'h01, "after_reset_pc");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_non_branch();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
